// File: rtl/jtag_user_dr_if.sv
// Bus between the JTAGG primitive side and the two-channel user data register.
interface jtag_user_dr_if #(
   parameter int unsigned DR_WIDTH = 8
);
   logic                jtdi;
   logic                jshift;
   logic                jupdate;
   logic                jce1;
   logic                jce2;
   logic [DR_WIDTH-1:0] dr1_status;
   logic [DR_WIDTH-1:0] dr2_status;
   logic                jtdo1;
   logic                jtdo2;
   logic [DR_WIDTH-1:0] dr1_q;
   logic [DR_WIDTH-1:0] dr2_q;
   logic                dr1_upd;
   logic                dr2_upd;

   modport master (
      output jtdi, jshift, jupdate, jce1, jce2, dr1_status, dr2_status,
      input  jtdo1, jtdo2, dr1_q, dr2_q, dr1_upd, dr2_upd
   );

   modport slave (
      input  jtdi, jshift, jupdate, jce1, jce2, dr1_status, dr2_status,
      output jtdo1, jtdo2, dr1_q, dr2_q, dr1_upd, dr2_upd
   );
endinterface

// File: rtl/jtag_user_dr.sv
// Two DR_WIDTH-bit JTAG user data registers (ER1/ER2) behind the JTAGG primitive, jtck domain.
// JTAG_DR_CAPTURE_STATUS_EN: capture loads drN_status instead of the drN_q shadow value.
module jtag_user_dr #(
   parameter int unsigned          DR_WIDTH    = 8,
   parameter logic [DR_WIDTH-1:0]  SHADOW_INIT = '0
) (
   input  logic           jtck,
   input  logic           jrst,
   jtag_user_dr_if.slave  bus
);

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_CH1  = 2'd1,
      SEL_CH2  = 2'd2
   } sel_e;

   sel_e                sel;
   logic                jshift_dly;
   logic [DR_WIDTH-1:0] sr1;
   logic [DR_WIDTH-1:0] sr2;
   logic [DR_WIDTH-1:0] nxt1;
   logic [DR_WIDTH-1:0] nxt2;
   logic [DR_WIDTH-1:0] cap1_src;
   logic [DR_WIDTH-1:0] cap2_src;
   logic                cap1_c;
   logic                cap2_c;

   // Shift-right with TDI entering at the MSB; data leaves LSB first.
   generate
      if (DR_WIDTH == 1) begin : g_nxt_1
         assign nxt1 = bus.jtdi;
         assign nxt2 = bus.jtdi;
      end else begin : g_nxt_n
         assign nxt1 = {bus.jtdi, sr1[DR_WIDTH-1:1]};
         assign nxt2 = {bus.jtdi, sr2[DR_WIDTH-1:1]};
      end
   endgenerate

`ifdef JTAG_DR_CAPTURE_STATUS_EN
   assign cap1_src = bus.dr1_status;
   assign cap2_src = bus.dr2_status;
`else
   logic unused_status;
   assign unused_status = ^{bus.dr1_status, bus.dr2_status};
   assign cap1_src      = bus.dr1_q;
   assign cap2_src      = bus.dr2_q;
`endif

   // Capture needs jshift low; ER1 wins when both enables are raised.
   always_comb begin
      cap1_c = bus.jce1 & ~bus.jshift;
      cap2_c = bus.jce2 & ~bus.jshift & ~bus.jce1;
   end

   always_ff @(posedge jtck) begin
      if (jrst) begin
         sel         <= SEL_NONE;
         jshift_dly  <= 1'b0;
         sr1         <= '0;
         sr2         <= '0;
         bus.dr1_q   <= SHADOW_INIT;
         bus.dr2_q   <= SHADOW_INIT;
         bus.dr1_upd <= 1'b0;
         bus.dr2_upd <= 1'b0;
      end else begin
         jshift_dly <= bus.jshift;

         if (cap1_c) begin
            sel <= SEL_CH1;
         end else if (cap2_c) begin
            sel <= SEL_CH2;
         end

         // Middle and exit cycles both shift, since jshift_dly covers both.
         if (cap1_c) begin
            sr1 <= cap1_src;
         end else if (sel == SEL_CH1 && jshift_dly) begin
            sr1 <= nxt1;
         end

         if (cap2_c) begin
            sr2 <= cap2_src;
         end else if (sel == SEL_CH2 && jshift_dly) begin
            sr2 <= nxt2;
         end

         bus.dr1_upd <= bus.jupdate && (sel == SEL_CH1);
         bus.dr2_upd <= bus.jupdate && (sel == SEL_CH2);
         if (bus.jupdate && sel == SEL_CH1) begin
            bus.dr1_q <= sr1;
         end
         if (bus.jupdate && sel == SEL_CH2) begin
            bus.dr2_q <= sr2;
         end
      end
   end

   // TDO looks one bit ahead during middle shift cycles to hide the register delay.
   always_comb begin
      bus.jtdo1 = 1'b0;
      bus.jtdo2 = 1'b0;
      if (!jrst && bus.jshift) begin
         if (sel == SEL_CH1) begin
            bus.jtdo1 = jshift_dly ? nxt1[0] : sr1[0];
         end
         if (sel == SEL_CH2) begin
            bus.jtdo2 = jshift_dly ? nxt2[0] : sr2[0];
         end
      end
   end

endmodule

// File: tb/tb_jtag_user_dr.sv
// Directed bench for jtag_user_dr: writes, read-backs, dual capture, held update, reset mid-shift.
module tb_jtag_user_dr;

   localparam int unsigned W = 8;

   logic jtck = 1'b0;
   logic jrst;
   int   errors = 0;
   int   checks = 0;

   always #5 jtck = ~jtck;

   jtag_user_dr_if #(.DR_WIDTH(W)) bus ();

   jtag_user_dr #(
      .DR_WIDTH    (W),
      .SHADOW_INIT (8'h00)
   ) dut (
      .jtck (jtck),
      .jrst (jrst),
      .bus  (bus.slave)
   );

`ifdef JTAG_DR_CAPTURE_STATUS_EN
   localparam logic STATUS_MODE = 1'b1;
`else
   localparam logic STATUS_MODE = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // ch: 1 = ER1, 2 = ER2, 3 = both enables (ER1 must win).
   task automatic dr_scan(input int ch, input logic [7:0] din, input logic [7:0] tdo_exp,
                          input logic [7:0] q1_exp, input logic [7:0] q2_exp);
      logic b;
      logic tdo_sel;
      logic tdo_oth;
      @(negedge jtck);
      bus.jce1   = (ch != 2);
      bus.jce2   = (ch != 1);
      bus.jshift = 1'b0;
      bus.jtdi   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge jtck);
         b          = (i == 0) ? 1'b0 : din[(i + 7) % 8];
         bus.jshift = 1'b1;
         bus.jtdi   = b;
         #1;
         tdo_sel = (ch == 2) ? bus.jtdo2 : bus.jtdo1;
         tdo_oth = (ch == 2) ? bus.jtdo1 : bus.jtdo2;
         chk($sformatf("tdo_ch%0d_bit%0d", ch, i), 32'(tdo_sel), 32'(tdo_exp[i]));
         chk($sformatf("tdo_idle_ch%0d_bit%0d", ch, i), 32'(tdo_oth), 32'd0);
      end
      @(negedge jtck);
      bus.jshift = 1'b0;
      bus.jce1   = 1'b0;
      bus.jce2   = 1'b0;
      bus.jtdi   = din[7];
      #1;
      chk("tdo_exit", 32'({bus.jtdo1, bus.jtdo2}), 32'd0);
      @(negedge jtck);
      bus.jtdi    = 1'b0;
      bus.jupdate = 1'b1;
      @(negedge jtck);
      bus.jupdate = 1'b0;
      #1;
      chk($sformatf("dr1_q_ch%0d", ch), 32'(bus.dr1_q), 32'(q1_exp));
      chk($sformatf("dr2_q_ch%0d", ch), 32'(bus.dr2_q), 32'(q2_exp));
      chk($sformatf("upd_ch%0d", ch), 32'({bus.dr1_upd, bus.dr2_upd}), (ch == 2) ? 32'd1 : 32'd2);
      @(negedge jtck);
      #1;
      chk($sformatf("upd_drop_ch%0d", ch), 32'({bus.dr1_upd, bus.dr2_upd}), 32'd0);
   endtask

   initial begin
      jrst           = 1'b1;
      bus.jtdi       = 1'b0;
      bus.jshift     = 1'b0;
      bus.jupdate    = 1'b0;
      bus.jce1       = 1'b0;
      bus.jce2       = 1'b0;
      bus.dr1_status = 8'hA5;
      bus.dr2_status = 8'h3C;

      // Reset state
      repeat (2) @(negedge jtck);
      #1;
      chk("rst_dr1_q", 32'(bus.dr1_q), 32'h00);
      chk("rst_dr2_q", 32'(bus.dr2_q), 32'h00);
      chk("rst_tdo", 32'({bus.jtdo1, bus.jtdo2}), 32'd0);
      chk("rst_upd", 32'({bus.dr1_upd, bus.dr2_upd}), 32'd0);
      @(negedge jtck);
      jrst = 1'b0;

      // Ch1 write, then read back (capture source differs by build)
      dr_scan(1, 8'hA5, STATUS_MODE ? 8'hA5 : 8'h00, 8'hA5, 8'h00);
      dr_scan(1, 8'h00, 8'hA5, 8'h00, 8'h00);
      // Ch2 write and read back
      dr_scan(2, 8'h3C, STATUS_MODE ? 8'h3C : 8'h00, 8'h00, 8'h3C);
      dr_scan(2, 8'h3C, 8'h3C, 8'h00, 8'h3C);
      // Both enables on capture: ER1 takes it, ch2 untouched
      dr_scan(3, 8'h5A, STATUS_MODE ? 8'hA5 : 8'h00, 8'h5A, 8'h3C);

      // Held jupdate: one write and pulse per cycle
      @(negedge jtck);
      bus.jupdate = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge jtck);
         #1;
         chk($sformatf("held_upd_%0d", k), 32'({bus.dr1_upd, bus.dr2_upd}), 32'd2);
         chk($sformatf("held_q_%0d", k), 32'(bus.dr1_q), 32'h5A);
      end
      bus.jupdate = 1'b0;

      // Reset after 4 of 8 shift bits of 0xFF
      @(negedge jtck);
      bus.jce1   = 1'b1;
      bus.jshift = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge jtck);
         bus.jshift = 1'b1;
         bus.jtdi   = 1'b1;
      end
      @(negedge jtck);
      jrst       = 1'b1;
      bus.jshift = 1'b0;
      bus.jce1   = 1'b0;
      bus.jtdi   = 1'b0;
      #1;
      chk("midrst_tdo", 32'({bus.jtdo1, bus.jtdo2}), 32'd0);
      repeat (2) @(negedge jtck);
      jrst        = 1'b0;
      bus.jupdate = 1'b1;
      @(negedge jtck);
      bus.jupdate = 1'b0;
      #1;
      chk("midrst_upd", 32'({bus.dr1_upd, bus.dr2_upd}), 32'd0);
      chk("midrst_dr1_q", 32'(bus.dr1_q), 32'h00);
      chk("midrst_dr2_q", 32'(bus.dr2_q), 32'h00);
      @(negedge jtck);
      #1;
      chk("midrst_upd_after", 32'({bus.dr1_upd, bus.dr2_upd}), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jtag_user_dr.md
Name: jtag_user_dr

Overview:
- Parametrised successor to the single-bit ECP5 JTAGG user data register.
- Provides two independent DR_WIDTH-bit user data registers: channel 1 on ER1 (JCE1/JTDO1) and channel 2 on ER2 (JCE2/JTDO2).
- Each channel has a shift register and a shadow (update) register, and pulses an update strobe into the fabric.
- Sits directly behind the JTAGG primitive and runs in the jtck domain.

Parameters:
- DR_WIDTH, 8, bits per channel shift/shadow register (≥1).
- SHADOW_INIT, 0, reset value of both shadow registers (DR_WIDTH bits).

Ports:
- jtck  input  1  JTAGG JTCK; only clock.
- jrst  input  1  synchronous, active-high reset, sampled on posedge jtck.
- jtdi  input  1  JTAGG JTDI (reclocked TDI).
- jshift  input  1  JTAGG JSHIFT.
- jupdate  input  1  JTAGG JUPDATE.
- jce1  input  1  JTAGG JCE1 (ER1 selected, capture/shift).
- jce2  input  1  JTAGG JCE2 (ER2 selected, capture/shift).
- dr1_status  input  DR_WIDTH  capture source for ch1 (optional feature).
- dr2_status  input  DR_WIDTH  capture source for ch2 (optional feature).
- jtdo1  output  1  to JTAGG JTDO1, combinational.
- jtdo2  output  1  to JTAGG JTDO2, combinational.
- dr1_q  output  DR_WIDTH  ch1 shadow register.
- dr2_q  output  DR_WIDTH  ch2 shadow register.
- dr1_upd  output  1  one-cycle pulse when dr1_q is written.
- dr2_upd  output  1  one-cycle pulse when dr2_q is written.

Behaviour:
- Reset (jrst=1 at posedge jtck):
  - sr1/sr2 = 0; dr1_q/dr2_q = SHADOW_INIT.
  - sel = NONE; jshift_dly = 0; dr*_upd = 0.
  - jtdo1/jtdo2 are combinational and evaluate to 0 while reset is held (sel=NONE).
  - Reset mid-shift discards the partial shift; no update pulse follows.
- Channel select register sel ∈ {NONE, CH1, CH2}:
  - Capture event: jceN=1 with jshift=0.
  - Capture sets sel to that channel and loads srN from the capture source (see Optional Feature).
  - jce1 and jce2 both asserted on a capture cycle: CH1 wins; ch2 is untouched.
- Shift (selected channel only; the unselected sr holds). Let nxt = {jtdi, sr[DR_WIDTH-1:1]}.
  - Entry cycle (jshift=1, jshift_dly=0): JTDI is not yet valid. No shift; jtdoN = srN[0].
  - Middle (jshift=1, jshift_dly=1): srN <= nxt; jtdoN = nxt[0] (equals jtdi when DR_WIDTH=1, else srN[1]). This avoids an extra TDO delay.
  - Exit cycle (jshift=0, jshift_dly=1): srN <= nxt to absorb the last JTDI bit; jtdoN = 0.
  - A Shift-DR with N TCK cycles performs exactly N shifts and presents srN[0..N-1] on TDO, LSB first.
  - Otherwise jtdo1 = jtdo2 = 0; the unselected channel's jtdo is always 0.
- Update: jupdate=1 with sel=CHN:
  - drN_q <= srN at the next edge; drN_upd = 1 for exactly that one cycle.
  - jupdate with sel=NONE is ignored.
  - jupdate held for multiple cycles: one write per cycle, one pulse per cycle.
- Priority within the selected channel: capture > exit-shift > shift. Update is independent (uses srN pre-edge).
- Capture during an active jshift never occurs with the JTAGG primitive; if it does, shift wins (capture requires jshift=0).
- Latency: TDI bit to srN[DR_WIDTH-1] = 1 cycle; last shift bit to drN_q = 1 cycle after jupdate.

Optional Feature:
- Macro JTAG_DR_CAPTURE_STATUS_EN.
- Defined: capture loads srN <= drN_status, giving a read-back of live fabric status.
- Undefined: capture loads srN <= drN_q (read-back of last written value); drN_status inputs are unused.

Test Plan:
- Reset: jrst=1 for 2 cycles → dr1_q = dr2_q = SHADOW_INIT = 0x00, jtdo1 = jtdo2 = 0, upd = 0.
- Ch1 write: capture on jce1, shift 0xA5 LSB first over 8 Shift-DR cycles, then jupdate → dr1_q = 0xA5, one dr1_upd pulse, dr2_q unchanged, jtdo2 = 0 throughout.
- Ch1 read-back (macro undefined): after the 0xA5 write, capture plus 8 shifts of 0x00 → jtdo1 sequence 1,0,1,0,0,1,0,1; the following update yields dr1_q = 0x00.
- Ch2 status (macro defined): dr2_status = 0x3C, capture on jce2, shift 8 → jtdo2 sequence 0,0,1,1,1,1,0,0.
- Simultaneous jce1 & jce2 capture, shift 0x5A, update → dr1_q = 0x5A, dr2_q unchanged, only dr1_upd pulses.
- Reset after 4 of 8 shift bits of 0xFF → sr1 = 0, sel = NONE; subsequent jupdate produces no dr*_upd pulse and dr1_q = 0x00.
